mmio_router: RTL and testbench

Parametrised successor of the two-way uncache/dcache splitter: routes each core load/store to one of `NCH` downstream memory channels, such as dcache, the uncached AXI arbiter or the CLINT. Routing uses a per-channel address region table. The block registers the request, holds exactly one transaction outstanding and returns registered read data with a one-cycle finish pulse. It sits between the LSU/MEM stage and the memory subsystem, and optionally reports hung transactions through a timeout.

---
 rtl/mmio_router_pkg.sv | 27 ++
 rtl/mmio_addr_decode.sv | 42 ++++
 rtl/mmio_router.sv | 168 ++++++++++++++++
 tb/tb_mmio_router.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_router_pkg.sv
// Shared types and constants for the MMIO router: FSM states, default
// address regions and channel indices.
package mmio_router_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Channel index width covers the maximum of 8 channels.
    localparam int CH_IDX_W = 3;

    localparam logic [63:0] CLINT_START   = 64'h0000_0000_0200_0000;
    localparam logic [63:0] CLINT_END     = 64'h0000_0000_0200_FFFF;
    localparam logic [63:0] UART_START    = 64'h0000_0000_1000_0000;
    localparam logic [63:0] UART_END      = 64'h0000_0000_1000_0FFF;
    localparam logic [63:0] SPICTRL_START = 64'h0000_0000_1000_1000;
    localparam logic [63:0] SPICTRL_END   = 64'h0000_0000_1000_1FFF;
    localparam logic [63:0] SPI_START     = 64'h0000_0000_3000_0000;
    localparam logic [63:0] SPI_END       = 64'h0000_0000_3FFF_FFFF;

    localparam int CH_DCACHE  = 0;
    localparam int CH_UNCACHE = 1;
    localparam int CH_CLINT   = 2;

endpackage

// File: rtl/mmio_addr_decode.sv
// Region table lookup: lowest-index matching channel wins, otherwise the
// default channel. Produces both a one-hot select and the binary index.
module mmio_addr_decode
    import mmio_router_pkg::*;
#(
    parameter int                NCH          = 3,
    parameter logic [NCH*64-1:0] REGION_BASE  = '0,
    parameter logic [NCH*64-1:0] REGION_LIMIT = '0,
    parameter int                DEF_CH       = 0
) (
    input  logic [63:0]         i_addr,
    output logic [NCH-1:0]      o_sel_oh,
    output logic [CH_IDX_W-1:0] o_sel_idx
);

    logic [NCH-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_hit
            // An empty region (limit < base) can never satisfy both bounds.
            assign w_hit[gi] = (i_addr >= REGION_BASE[gi*64 +: 64]) &&
                               (i_addr <= REGION_LIMIT[gi*64 +: 64]);
        end
    endgenerate

    // Scan from the top so the lowest matching index is the last to write.
    always_comb begin
        o_sel_idx = CH_IDX_W'(DEF_CH);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_hit[i]) o_sel_idx = CH_IDX_W'(i);
        end
    end

    always_comb begin
        o_sel_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            o_sel_oh[i] = (o_sel_idx == CH_IDX_W'(i));
        end
    end

endmodule

// File: rtl/mmio_router.sv
// Routes one core load/store at a time to one of NCH memory channels by
// address region. Optional hang timeout via MMIO_ROUTER_TIMEOUT_EN.
module mmio_router
    import mmio_router_pkg::*;
#(
    parameter int                NCH          = 3,
    parameter logic [NCH*64-1:0] REGION_BASE  = {CLINT_START, UART_START, 64'd0},
    parameter logic [NCH*64-1:0] REGION_LIMIT = {CLINT_END, SPI_END, 64'd0},
    parameter int                DEF_CH       = 0,
    parameter int                TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       core_addr,
    input  logic [63:0]       core_data,
    input  logic [7:0]        core_mask,
    input  logic              core_we,
    input  logic              core_re,
    input  logic              fence_in,
    output logic [63:0]       in_core_data,
    output logic              in_core_finish,
    output logic              in_core_err,
    output logic [NCH-1:0]    mmio_sign,
    output logic [NCH*64-1:0] ch_addr,
    output logic [NCH*64-1:0] ch_data,
    output logic [NCH*8-1:0]  ch_mask,
    output logic [NCH-1:0]    ch_we,
    output logic [NCH-1:0]    ch_re,
    output logic              ch_fence,
    input  logic [NCH*64-1:0] in_ch_data,
    input  logic [NCH-1:0]    in_ch_finish
);

    state_t r_state;
    state_t w_state_nxt;

    logic [63:0]         r_addr;
    logic [63:0]         r_data;
    logic [7:0]          r_mask;
    logic                r_we;
    logic                r_re;
    logic [NCH-1:0]      r_sign;
    logic [CH_IDX_W-1:0] r_sel_idx;
    logic [63:0]         r_rdata;

    logic [NCH-1:0]      w_dec_oh;
    logic [CH_IDX_W-1:0] w_dec_idx;
    logic                w_req;
    logic                w_fin;
    logic                w_timeout;
    logic [63:0]         w_sel_rdata;

    mmio_addr_decode #(
        .NCH          (NCH),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT),
        .DEF_CH       (DEF_CH)
    ) u_dec (
        .i_addr    (core_addr),
        .o_sel_oh  (w_dec_oh),
        .o_sel_idx (w_dec_idx)
    );

    assign w_req = core_we | core_re;
    // Finish pulses from channels other than the latched one are masked off.
    assign w_fin = |(in_ch_finish & r_sign);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_sel_idx == CH_IDX_W'(i)) w_sel_rdata = in_ch_data[i*64 +: 64];
        end
    end

`ifdef MMIO_ROUTER_TIMEOUT_EN
    logic [31:0] r_cnt;
    logic        r_err;

    assign w_timeout   = (r_cnt == 32'(TIMEOUT_CYC));
    assign in_core_err = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 32'd1;
            // A finish in the timeout cycle takes precedence.
            if (w_fin)          r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign in_core_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_state_nxt = S_BUSY;
            S_BUSY: if (w_fin || w_timeout) w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_mask    <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_sign    <= '0;
            r_sel_idx <= '0;
            r_rdata   <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_addr    <= core_addr;
                r_data    <= core_data;
                r_mask    <= core_mask;
                r_we      <= core_we;
                // A combined we+re request is a write.
                r_re      <= core_re & ~core_we;
                r_sign    <= w_dec_oh;
                r_sel_idx <= w_dec_idx;
            end
            if (r_state == S_BUSY) begin
                if (w_fin)          r_rdata <= r_we ? 64'd0 : w_sel_rdata;
                else if (w_timeout) r_rdata <= '1;
            end
        end
    end

    always_comb begin
        ch_addr = '0;
        ch_data = '0;
        ch_mask = '0;
        ch_we   = '0;
        ch_re   = '0;
        if (r_state == S_BUSY) begin
            for (int i = 0; i < NCH; i++) begin
                if (r_sign[i]) begin
                    ch_addr[i*64 +: 64] = r_addr;
                    ch_data[i*64 +: 64] = r_data;
                    ch_mask[i*8 +: 8]   = r_mask;
                    ch_we[i]            = r_we;
                    ch_re[i]            = r_re;
                end
            end
        end
    end

    // Fences only pass while no transaction is in flight.
    assign ch_fence       = (r_state == S_IDLE) ? fence_in : 1'b0;
    assign in_core_finish = (r_state == S_RESP);
    assign in_core_data   = r_rdata;
    assign mmio_sign      = r_sign;

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router (3 channels, default region table).
module tb_mmio_router;
    localparam int NCH = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       core_addr, core_data;
    logic [7:0]        core_mask;
    logic              core_we, core_re, fence_in;
    logic [63:0]       in_core_data;
    logic              in_core_finish, in_core_err;
    logic [NCH-1:0]    mmio_sign;
    logic [NCH*64-1:0] ch_addr, ch_data;
    logic [NCH*8-1:0]  ch_mask;
    logic [NCH-1:0]    ch_we, ch_re;
    logic              ch_fence;
    logic [NCH*64-1:0] in_ch_data;
    logic [NCH-1:0]    in_ch_finish;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0;
    logic seen;

    mmio_router #(.NCH(NCH), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .core_addr(core_addr), .core_data(core_data), .core_mask(core_mask),
        .core_we(core_we), .core_re(core_re), .fence_in(fence_in),
        .in_core_data(in_core_data), .in_core_finish(in_core_finish),
        .in_core_err(in_core_err), .mmio_sign(mmio_sign),
        .ch_addr(ch_addr), .ch_data(ch_data), .ch_mask(ch_mask),
        .ch_we(ch_we), .ch_re(ch_re), .ch_fence(ch_fence),
        .in_ch_data(in_ch_data), .in_ch_finish(in_ch_finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; core_addr = '0; core_data = '0; core_mask = '0;
        core_we = 1'b0; core_re = 1'b0; fence_in = 1'b0;
        in_ch_data = '0; in_ch_finish = '0;
        tick(); tick();
        smp();
        chk("rst_fin",   64'(in_core_finish), 64'd0);
        chk("rst_data",  in_core_data, 64'd0);
        chk("rst_err",   64'(in_core_err), 64'd0);
        chk("rst_sign",  64'(mmio_sign), 64'd0);
        chk("rst_we",    64'(ch_we), 64'd0);
        chk("rst_re",    64'(ch_re), 64'd0);
        chk("rst_fence", 64'(ch_fence), 64'd0);
        tick(); rst = 1'b0;

        // Read to unmapped space -> dcache, channel latency 3
        tick(); t0 = cyc;
        core_addr = 64'h8000_0000; core_re = 1'b1;
        smp();
        chk("a_idle_re", 64'(ch_re), 64'd0);
        tick(); core_re = 1'b0;
        smp();
        chk("a_re",   64'(ch_re), 64'b001);
        chk("a_addr", ch_addr[63:0], 64'h8000_0000);
        chk("a_sign", 64'(mmio_sign), 64'b001);
        tick(); tick(); tick();
        in_ch_finish = 3'b001; in_ch_data[63:0] = 64'h1122_3344_5566_7788;
        smp();
        chk("a_fin_early", 64'(in_core_finish), 64'd0);
        tick(); in_ch_finish = '0;
        smp();
        chk("a_fin",  64'(in_core_finish), 64'd1);
        chk("a_lat",  64'(cyc - t0), 64'd5);
        chk("a_data", in_core_data, 64'h1122_3344_5566_7788);
        chk("a_err",  64'(in_core_err), 64'd0);
        chk("a_resp_re", 64'(ch_re), 64'd0);
        tick();
        smp();
        chk("a_fin_off", 64'(in_core_finish), 64'd0);

        // Write to UART -> ch1 only, zero channel latency
        t0 = cyc;
        core_addr = 64'h1000_0000; core_data = 64'hAB; core_mask = 8'h01; core_we = 1'b1;
        tick(); core_we = 1'b0;
        in_ch_finish = 3'b010; in_ch_data[127:64] = 64'hDEAD;
        smp();
        chk("b_we",    64'(ch_we), 64'b010);
        chk("b_re",    64'(ch_re), 64'd0);
        chk("b_mask",  64'(ch_mask), 64'h00_01_00);
        chk("b_addr1", ch_addr[127:64], 64'h1000_0000);
        chk("b_addr0", ch_addr[63:0], 64'd0);
        chk("b_addr2", ch_addr[191:128], 64'd0);
        chk("b_data1", ch_data[127:64], 64'hAB);
        chk("b_data0", ch_data[63:0] | ch_data[191:128], 64'd0);
        chk("b_sign",  64'(mmio_sign), 64'b010);
        tick(); in_ch_finish = '0;
        smp();
        chk("b_fin",  64'(in_core_finish), 64'd1);
        chk("b_lat",  64'(cyc - t0), 64'd2);
        chk("b_data", in_core_data, 64'd0);
        tick();

        // CLINT read with a spurious ch0 finish
        core_addr = 64'h0200_BFF8; core_re = 1'b1;
        tick(); core_re = 1'b0;
        in_ch_finish = 3'b001; in_ch_data[63:0] = 64'h5555;
        smp();
        chk("c_sign", 64'(mmio_sign), 64'b100);
        chk("c_re",   64'(ch_re), 64'b100);
        chk("c_addr2", ch_addr[191:128], 64'h0200_BFF8);
        tick(); in_ch_finish = 3'b100; in_ch_data[191:128] = 64'hCAFE_F00D;
        smp();
        chk("c_spur_fin", 64'(in_core_finish), 64'd0);
        chk("c_still_re", 64'(ch_re), 64'b100);
        tick(); in_ch_finish = '0;
        smp();
        chk("c_fin",  64'(in_core_finish), 64'd1);
        chk("c_data", in_core_data, 64'hCAFE_F00D);
        tick();

        // Reset two cycles into BUSY
        core_addr = 64'h8000_0000; core_re = 1'b1;
        tick(); core_re = 1'b0;
        tick(); rst = 1'b1; in_ch_finish = 3'b001;
        tick(); rst = 1'b0; in_ch_finish = '0;
        smp();
        chk("d_re",   64'(ch_re), 64'd0);
        chk("d_sign", 64'(mmio_sign), 64'd0);
        chk("d_fin",  64'(in_core_finish), 64'd0);
        chk("d_data", in_core_data, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); smp();
            if (in_core_finish) seen = 1'b1;
        end
        chk("d_no_fin", 64'(seen), 64'd0);
        // we+re together to SPI -> write on ch1
        tick();
        core_addr = 64'h3000_0000; core_data = 64'h1234; core_mask = 8'hFF;
        core_we = 1'b1; core_re = 1'b1;
        tick(); core_we = 1'b0; core_re = 1'b0;
        in_ch_finish = 3'b010; in_ch_data[127:64] = 64'h7777;
        smp();
        chk("d_we", 64'(ch_we), 64'b010);
        chk("d_wr_re", 64'(ch_re), 64'd0);
        tick(); in_ch_finish = '0;
        smp();
        chk("d_fin2", 64'(in_core_finish), 64'd1);
        chk("d_data2", in_core_data, 64'd0);
        tick();

        // Fence held off during BUSY
        core_addr = 64'h8000_0000; core_re = 1'b1;
        tick(); core_re = 1'b0; fence_in = 1'b1;
        smp();
        chk("e_fence_busy", 64'(ch_fence), 64'd0);
        tick(); in_ch_finish = 3'b001; in_ch_data[63:0] = 64'h42;
        smp();
        chk("e_fence_busy2", 64'(ch_fence), 64'd0);
        tick(); in_ch_finish = '0;
        smp();
        chk("e_fence_resp", 64'(ch_fence), 64'd0);
        chk("e_fin", 64'(in_core_finish), 64'd1);
        tick();
        smp();
        chk("e_fence_idle", 64'(ch_fence), 64'd1);
        fence_in = 1'b0;
        #2;
        chk("e_fence_drop", 64'(ch_fence), 64'd0);
        tick();

        // Channel never finishes
        t0 = cyc;
        core_addr = 64'h8000_0000; core_re = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            core_re = 1'b0;
            smp();
            if (in_core_finish) begin
                seen = 1'b1;
                break;
            end
        end
`ifdef MMIO_ROUTER_TIMEOUT_EN
        chk("f_seen", 64'(seen), 64'd1);
        chk("f_lat",  64'(cyc - t0), 64'd18);
        chk("f_data", in_core_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("f_err",  64'(in_core_err), 64'd1);
        chk("f_re",   64'(ch_re), 64'd0);
        tick(); in_ch_finish = 3'b001;
        smp();
        chk("f_late_fin", 64'(in_core_finish), 64'd0);
        tick(); in_ch_finish = '0;
`else
        chk("f_no_fin", 64'(seen), 64'd0);
        chk("f_hold_re", 64'(ch_re), 64'b001);
        chk("f_err0", 64'(in_core_err), 64'd0);
        rst = 1'b1;
        tick(); rst = 1'b0;
        smp();
        chk("f_rst_re", 64'(ch_re), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
